axis_to_axi4_wr_burst: RTL
==========================

AXIS_TO_AXI4_WR_BURST -- requirements
Module: axis_to_axi4_wr_burst

Interface
REQ-001 SHALL provide parameters, one per line:
  DSIZE, 64, stream/AXI data width in bits; power of 2, 8..1024.
  ASIZE, 32, AXI address width.
  IDSIZE, 4, AXI ID width.
  MAX_BURST, 16, maximum beats per AW burst; 1..256.
  FIFO_DEPTH, 32, data FIFO beats; power of 2, >= MAX_BURST.
  MAX_OUTSTANDING, 4, maximum AW bursts awaiting B; 1..15.
REQ-002 SHALL provide ports, one per line:
  axi_aclk  in  1  sole clock, all logic rising-edge.
  axi_aresetn  in  1  asynchronous active-low reset.
  addr  in  ASIZE  packet start byte address, sampled on each packet's first accepted beat.
  axis_tdata  in  DSIZE  stream data.
  axis_tkeep  in  DSIZE/8  byte enables.
  axis_tvalid  in  1  stream valid.
  axis_tlast  in  1  last beat of packet.
  axis_tready  out  1  stream ready.
  axi_awid  out  IDSIZE  burst ID.
  axi_awaddr  out  ASIZE  burst byte address.
  axi_awlen  out  8  beats minus one.
  axi_awsize  out  3  constant log2(DSIZE/8).
  axi_awburst  out  2  constant 2'b01 (INCR).
  axi_awvalid  out  1  address valid.
  axi_awready  in  1  address ready.
  axi_wdata  out  DSIZE  write data.
  axi_wstrb  out  DSIZE/8  equals stored tkeep (not inverted).
  axi_wlast  out  1  last beat of burst.
  axi_wvalid  out  1  data valid.
  axi_wready  in  1  data ready.
  axi_bid  in  IDSIZE  response ID, ignored.
  axi_bresp  in  2  response code.
  axi_bvalid  in  1  response valid.
  axi_bready  out  1  constant 1 after reset.
  err_flag  out  1  sticky: any bresp != 2'b00 seen.
  err_cnt  out  16  count of error responses, saturates at 16'hFFFF.

Function
REQ-003 SHALL split each tlast-delimited packet into bursts; burst closes on tlast, on reaching MAX_BURST beats, or on the beat ending at a 4 KB boundary; no burst crosses 4 KB.
REQ-004 SHALL force addr low log2(DSIZE/8) bits to zero; each following burst address = previous + beats*DSIZE/8 (ASIZE-bit wrap).
REQ-005 SHALL be store-and-forward per burst: a descriptor {addr, len} is written to a 4-entry descriptor FIFO on the closing beat handshake; AW issues only for complete bursts.
REQ-006 axis_tready SHALL equal (data FIFO not full) AND (descriptor FIFO not full).
REQ-007 SHALL run FSM IDLE -> AW -> W -> IDLE: IDLE goes to AW when descriptor FIFO non-empty and outstanding < MAX_OUTSTANDING; AW holds awvalid and stable fields until awready; W starts the cycle after the AW handshake and streams len+1 beats, wlast on the final one; after the final W handshake, IDLE.
REQ-008 With FSM idle and credit available, awvalid SHALL assert exactly 2 cycles after the closing-beat handshake.
REQ-009 wvalid SHALL deassert only when beats remain unavailable; data, strobe and wlast SHALL hold while wvalid && !wready.
REQ-010 awid SHALL start at 0 and increment by 1 (mod 2^IDSIZE) per AW handshake.
REQ-011 Outstanding counter SHALL +1 on AW handshake, -1 on bvalid, unchanged when both occur in the same cycle; never exceeds MAX_OUTSTANDING.
REQ-012 On bvalid with bresp != 0, err_cnt SHALL increment (saturating) and err_flag SHALL set, both visible the next cycle.

Reset
REQ-013 While axi_aresetn low, asynchronously: awvalid, wvalid, wlast, axis_tready, bready, err_flag = 0; err_cnt, awid, outstanding = 0; FIFOs empty; FSM IDLE; reset mid-burst abandons that burst with no further W beats.

Verification
REQ-014 40-beat packet, addr 0x1000, DSIZE=64 -> AW (0x1000, len 15, id 0), (0x1080, 15, id 1), (0x1100, 7, id 2); wlast on beats 16, 32, 40.
REQ-015 10 beats, addr 0x0FE0 -> AW (0x0FE0, len 3) then (0x1000, len 5).
REQ-016 bvalid held low, five 1-beat packets -> exactly 4 AW; 5th AW follows one B response.
REQ-017 wready held low -> axis_tready drops after 32 beats buffered; releases on first W handshake.
REQ-018 bresp 2'b10 once, then 2'b00 -> err_cnt 1, err_flag stays 1.
REQ-019 reset asserted during W beat 5 of 16 -> wvalid 0 immediately; after release first AW id 0.

Source files
------------

// File: rtl/axis_to_axi4_wr_burst_if.sv
// Stream-in / AXI4 write-out signal bundle for the AXIS-to-AXI4 burst bridge.
// master = bridge side, slave = stream source plus AXI memory side.
interface axis_to_axi4_wr_burst_if #(
  parameter int DSIZE  = 64,
  parameter int ASIZE  = 32,
  parameter int IDSIZE = 4
);
  logic [ASIZE-1:0]   addr;
  logic [DSIZE-1:0]   axis_tdata;
  logic [DSIZE/8-1:0] axis_tkeep;
  logic               axis_tvalid;
  logic               axis_tlast;
  logic               axis_tready;

  logic [IDSIZE-1:0]  axi_awid;
  logic [ASIZE-1:0]   axi_awaddr;
  logic [7:0]         axi_awlen;
  logic [2:0]         axi_awsize;
  logic [1:0]         axi_awburst;
  logic               axi_awvalid;
  logic               axi_awready;

  logic [DSIZE-1:0]   axi_wdata;
  logic [DSIZE/8-1:0] axi_wstrb;
  logic               axi_wlast;
  logic               axi_wvalid;
  logic               axi_wready;

  logic [IDSIZE-1:0]  axi_bid;
  logic [1:0]         axi_bresp;
  logic               axi_bvalid;
  logic               axi_bready;

  modport master (
    input  addr, axis_tdata, axis_tkeep, axis_tvalid, axis_tlast,
    output axis_tready,
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready
  );

  modport slave (
    output addr, axis_tdata, axis_tkeep, axis_tvalid, axis_tlast,
    input  axis_tready,
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready
  );
endinterface

// File: rtl/axis_to_axi4_wr_burst.sv
// Store-and-forward AXIS packet to AXI4 INCR write-burst bridge with 4 KB splitting,
// outstanding-burst credit and sticky write-response error tracking.
//   state  | meaning
//   S_IDLE | wait for a complete burst descriptor and a free credit
//   S_AW   | present AW until awready
//   S_W    | stream len+1 beats from the data FIFO, wlast on the final one
module axis_to_axi4_wr_burst #(
  parameter int DSIZE           = 64,
  parameter int ASIZE           = 32,
  parameter int IDSIZE          = 4,
  parameter int MAX_BURST       = 16,
  parameter int FIFO_DEPTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  axis_to_axi4_wr_burst_if.master bus,
  output logic                    err_flag,
  output logic [15:0]             err_cnt
);
  localparam int KSIZE = DSIZE / 8;
  localparam int DPW   = $clog2(FIFO_DEPTH);
  localparam logic [ASIZE-1:0] BEAT_BYTES = ASIZE'(KSIZE);
  localparam logic [ASIZE-1:0] LOW_MASK   = ASIZE'(KSIZE - 1);
  localparam logic [8:0]       BURST_MAX  = 9'(MAX_BURST);
  localparam logic [3:0]       OUT_MAX    = 4'(MAX_OUTSTANDING);
  localparam logic [DPW:0]     DFIFO_FULL = (DPW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

  state_t            state, state_nxt;
  logic              run;
  logic              beat_push, w_hs, aw_hs, b_hs;
  logic              aw_valid, w_valid, w_last, desc_pop;

  logic [DSIZE-1:0]  dat_mem  [FIFO_DEPTH];
  logic [KSIZE-1:0]  keep_mem [FIFO_DEPTH];
  logic [DPW-1:0]    d_wr, d_rd;
  logic [DPW:0]      d_count;
  logic              d_full, d_empty;

  logic [ASIZE-1:0]  desc_addr_mem [4];
  logic [7:0]        desc_len_mem  [4];
  logic [1:0]        q_wr, q_rd;
  logic [2:0]        q_count;
  logic              q_full, q_empty, desc_push;

  logic              in_pkt, close_burst;
  logic [8:0]        beat_cnt;
  logic [ASIZE-1:0]  beat_addr, burst_addr, cur_addr, start_addr, next_addr;

  logic [ASIZE-1:0]  aw_addr;
  logic [7:0]        aw_len, beats_left;
  logic [IDSIZE-1:0] aw_id;
  logic [3:0]        outstanding;

  assign d_full  = (d_count == DFIFO_FULL);
  assign d_empty = (d_count == '0);
  assign q_full  = (q_count == 3'd4);
  assign q_empty = (q_count == 3'd0);

  assign bus.axis_tready = run && !d_full && !q_full;
  assign bus.axi_bready  = run;
  assign beat_push = bus.axis_tvalid && bus.axis_tready;
  assign w_hs      = w_valid && bus.axi_wready;
  assign aw_hs     = aw_valid && bus.axi_awready;
  assign b_hs      = bus.axi_bvalid && bus.axi_bready;
  assign desc_push = beat_push && close_burst;

  // A burst closes on tlast, on its beat limit, or when the next beat would start a new 4 KB page.
  always_comb begin
    cur_addr    = in_pkt ? beat_addr : (bus.addr & ~LOW_MASK);
    start_addr  = (beat_cnt == 9'd0) ? cur_addr : burst_addr;
    next_addr   = cur_addr + BEAT_BYTES;
    close_burst = bus.axis_tlast || ((beat_cnt + 9'd1) == BURST_MAX) ||
                  (next_addr[11:0] == 12'h000);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      run        <= 1'b0;
      in_pkt     <= 1'b0;
      beat_cnt   <= '0;
      beat_addr  <= '0;
      burst_addr <= '0;
    end else begin
      run <= 1'b1;
      if (beat_push) begin
        in_pkt     <= !bus.axis_tlast;
        beat_addr  <= next_addr;
        burst_addr <= start_addr;
        beat_cnt   <= close_burst ? 9'd0 : beat_cnt + 9'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (beat_push) begin
      dat_mem[d_wr]  <= bus.axis_tdata;
      keep_mem[d_wr] <= bus.axis_tkeep;
    end
    if (desc_push) begin
      desc_addr_mem[q_wr] <= start_addr;
      desc_len_mem[q_wr]  <= beat_cnt[7:0];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      d_wr    <= '0;
      d_rd    <= '0;
      d_count <= '0;
      q_wr    <= '0;
      q_rd    <= '0;
      q_count <= '0;
    end else begin
      if (beat_push) d_wr <= d_wr + DPW'(1);
      if (w_hs)      d_rd <= d_rd + DPW'(1);
      if (beat_push && !w_hs)      d_count <= d_count + (DPW + 1)'(1);
      else if (!beat_push && w_hs) d_count <= d_count - (DPW + 1)'(1);
      if (desc_push) q_wr <= q_wr + 2'd1;
      if (desc_pop)  q_rd <= q_rd + 2'd1;
      if (desc_push && !desc_pop)      q_count <= q_count + 3'd1;
      else if (!desc_push && desc_pop) q_count <= q_count - 3'd1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    w_last    = 1'b0;
    desc_pop  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!q_empty && (outstanding < OUT_MAX)) begin
          desc_pop  = 1'b1;
          state_nxt = S_AW;
        end
      end
      S_AW: begin
        aw_valid = 1'b1;
        if (bus.axi_awready) state_nxt = S_W;
      end
      S_W: begin
        w_valid = !d_empty;
        w_last  = (beats_left == 8'd0);
        if (w_valid && bus.axi_wready && w_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_addr     <= '0;
      aw_len      <= '0;
      beats_left  <= '0;
      aw_id       <= '0;
      outstanding <= '0;
      err_flag    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (desc_pop) begin
        aw_addr <= desc_addr_mem[q_rd];
        aw_len  <= desc_len_mem[q_rd];
      end
      if (aw_hs) begin
        beats_left <= aw_len;
        aw_id      <= aw_id + IDSIZE'(1);
      end else if (w_hs && !w_last) begin
        beats_left <= beats_left - 8'd1;
      end
      if (aw_hs && !b_hs)                          outstanding <= outstanding + 4'd1;
      else if (!aw_hs && b_hs && outstanding != 0) outstanding <= outstanding - 4'd1;
      if (b_hs && bus.axi_bresp != 2'b00) begin
        err_flag <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

  assign bus.axi_awid    = aw_id;
  assign bus.axi_awaddr  = aw_addr;
  assign bus.axi_awlen   = aw_len;
  assign bus.axi_awsize  = 3'($clog2(KSIZE));
  assign bus.axi_awburst = 2'b01;
  assign bus.axi_awvalid = aw_valid;
  assign bus.axi_wdata   = dat_mem[d_rd];
  assign bus.axi_wstrb   = keep_mem[d_rd];
  assign bus.axi_wlast   = w_last;
  assign bus.axi_wvalid  = w_valid;
endmodule
